fetch_prefetch_unit: RTL

//  Instruction-fetch front end feeding the IF/ID pipeline register. Holds the fetch PC and issues
//  in-order requests to a variable-latency instruction memory over a req/gnt + rvalid handshake.

---
 rtl/fetch_prefetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues in-order imem requests, buffers returned words with their
// PC+4 in a prefetch FIFO, and flushes/discards stale responses on a redirect.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [31:0] fetch_pc,
  output logic        fsm_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_q, rd_q, tag_wr_q, tag_rd_q;
  logic [31:0]     tag_mem_q  [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc4_mem_q  [DEPTH];

  logic [CW:0]     inflight;
  logic            grant, rsp, push, pop;

  // Handshake: a request transfers on imem_req & imem_gnt; a response is only accepted
  // while something is in flight, and responses come back in request order.
  assign inflight  = {1'b0, count_q} + {1'b0, out_q};
  assign imem_req  = !rst && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && (out_q != '0);
  assign push      = rsp && (drop_q == '0) && !redirect;
  assign pop       = (count_q != '0) && !stall && !redirect;

  assign if_valid  = (count_q != '0);
  assign if_inst   = if_valid ? inst_mem_q[rd_q] : 32'h0;
  assign if_pc4    = if_valid ? pc4_mem_q[rd_q]  : 32'h0;
  assign fetch_pc  = fetch_pc_q;
  assign fsm_state = state_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    state_d    = state_q;

    if (grant) out_d = out_d + CW'(1);
    if (rsp)   out_d = out_d - CW'(1);
    if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (push) count_d = count_d + CW'(1);
    if (pop)  count_d = count_d - CW'(1);
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

    // Every request still in flight after this edge belongs to the old path.
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      drop_d     = out_d;
    end

    case (state_q)
      FETCH:   if (redirect && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      if (grant) tag_wr_q <= tag_wr_q + PW'(1);
      if (rsp)   tag_rd_q <= tag_rd_q + PW'(1);
      if (push)  wr_q <= wr_q + PW'(1);
      if (redirect)  rd_q <= wr_q;
      else if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem_q[tag_wr_q] <= fetch_pc_q + 32'd4;
    if (push) begin
      inst_mem_q[wr_q] <= imem_rdata;
      pc4_mem_q[wr_q]  <= tag_mem_q[tag_rd_q];
    end
  end
endmodule
